// File: rtl/vending_machine_pkg.sv
// Shared constants for the vending_machine controller: state encoding,
// coin codes, product price and small credit-lookup helpers.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [4:0] PRICE = 5'd15;

  function automatic logic [4:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:              return 5'd5;
      COIN_10:             return 5'd10;
      COIN_NONE, COIN_BAD: return 5'd0;
      default:             return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] credit_of(input state_t s);
    case (s)
      S5:      return 5'd5;
      S10:     return 5'd10;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Single-product coin vending controller (price 15, coins 5/10).
// Optional change-return strobe enabled by defining VENDING_CHANGE_EN.
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] coin,
  output logic       dispensed
`ifdef VENDING_CHANGE_EN
  ,
  output logic       change
`endif
);

  state_t     curr_state;
  state_t     next_state;
  logic [4:0] total;
  logic       disp_next;
  logic       change_next;

  // State register; strobes are registered on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      curr_state <= S0;
      dispensed  <= 1'b0;
`ifdef VENDING_CHANGE_EN
      change     <= 1'b0;
`endif
    end else begin
      curr_state <= next_state;
      dispensed  <= disp_next;
`ifdef VENDING_CHANGE_EN
      change     <= change_next;
`endif
    end
  end

  always_comb begin
    next_state = curr_state;
    case (curr_state)
      S0: begin
        if (coin == COIN_5)       next_state = S5;
        else if (coin == COIN_10) next_state = S10;
      end
      S5: begin
        if (coin == COIN_5)       next_state = S10;
        else if (coin == COIN_10) next_state = S0;
      end
      S10: begin
        if (coin == COIN_5 || coin == COIN_10) next_state = S0;
      end
      default: next_state = S0;
    endcase
  end

  // A sale completes when held credit plus the sampled coin reaches PRICE;
  // the unreachable encoding maps to zero credit, so it never dispenses.
  always_comb begin
    total       = credit_of(curr_state) + coin_value(coin);
    disp_next   = (total >= PRICE);
    change_next = (total > PRICE);
  end

`ifndef VENDING_CHANGE_EN
  logic unused_change;
  assign unused_change = change_next;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine (default and
// VENDING_CHANGE_EN builds).
module tb_vending_machine;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       dispensed;
`ifdef VENDING_CHANGE_EN
  logic       change;
`endif

  int unsigned n_tests;
  int unsigned n_fail;
  int unsigned pulses;

  vending_machine dut (
    .clock     (clock),
    .reset     (reset),
    .coin      (coin),
    .dispensed (dispensed)
`ifdef VENDING_CHANGE_EN
    ,
    .change    (change)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a coin away from the edge, then check state and strobes after it.
  task automatic step(input string tag, input logic [1:0] c, input logic [1:0] exp_state,
                      input logic exp_disp, input logic exp_change);
    @(negedge clock);
    coin = c;
    @(posedge clock);
    #1;
    check({tag, ".state"}, 32'(dut.curr_state), 32'(exp_state));
    check({tag, ".disp"}, 32'(dispensed), 32'(exp_disp));
`ifdef VENDING_CHANGE_EN
    check({tag, ".change"}, 32'(change), 32'(exp_change));
`else
    if (exp_change) pulses = pulses + 0;
`endif
    if (dispensed) pulses++;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pulses  = 0;
    reset   = 1'b1;
    coin    = 2'b01;

    // Coin present during reset must have no effect.
    #6;
    check("rst_a.state", 32'(dut.curr_state), 32'd0);
    check("rst_a.disp", 32'(dispensed), 32'd0);
    #10;
    check("rst_b.state", 32'(dut.curr_state), 32'd0);
    check("rst_b.disp", 32'(dispensed), 32'd0);
    #4;
    coin  = 2'b00;
    reset = 1'b0;

    // Mid-credit reset in S10: asynchronous clear, no pulse.
    step("mid0", 2'b10, 2'b10, 1'b0, 1'b0);
    @(negedge clock);
    coin  = 2'b01;
    reset = 1'b1;
    #1;
    check("mid_async.state", 32'(dut.curr_state), 32'd0);
    check("mid_async.disp", 32'(dispensed), 32'd0);
    @(posedge clock);
    #1;
    check("mid_held.state", 32'(dut.curr_state), 32'd0);
    check("mid_held.disp", 32'(dispensed), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    coin  = 2'b00;

    // Six 5-unit coins.
    pulses = 0;
    step("n5_1", 2'b01, 2'b01, 1'b0, 1'b0);
    step("n5_2", 2'b01, 2'b10, 1'b0, 1'b0);
    step("n5_3", 2'b01, 2'b00, 1'b1, 1'b0);
    step("n5_4", 2'b01, 2'b01, 1'b0, 1'b0);
    step("n5_5", 2'b01, 2'b10, 1'b0, 1'b0);
    step("n5_6", 2'b01, 2'b00, 1'b1, 1'b0);
    check("n5_pulses", pulses, 32'd2);

    // Five 10-unit coins (overpay each pair).
    pulses = 0;
    step("n10_1", 2'b10, 2'b10, 1'b0, 1'b0);
    step("n10_2", 2'b10, 2'b00, 1'b1, 1'b1);
    step("n10_3", 2'b10, 2'b10, 1'b0, 1'b0);
    step("n10_4", 2'b10, 2'b00, 1'b1, 1'b1);
    step("n10_5", 2'b10, 2'b10, 1'b0, 1'b0);
    check("n10_pulses", pulses, 32'd2);

    // S10 + 5 exact sale, then S5 + 10.
    step("s10c5", 2'b01, 2'b00, 1'b1, 1'b0);
    step("s5a", 2'b01, 2'b01, 1'b0, 1'b0);
    step("s5c10", 2'b10, 2'b00, 1'b1, 1'b0);
    step("drop", 2'b00, 2'b00, 1'b0, 1'b0);

    // Idle and invalid codes hold S5.
    step("hold0", 2'b01, 2'b01, 1'b0, 1'b0);
    step("hold1", 2'b00, 2'b01, 1'b0, 1'b0);
    step("hold2", 2'b11, 2'b01, 1'b0, 1'b0);
    step("hold3", 2'b11, 2'b01, 1'b0, 1'b0);
    step("hold4", 2'b01, 2'b10, 1'b0, 1'b0);
    step("hold5", 2'b01, 2'b00, 1'b1, 1'b0);

    // Invalid code in S10 and S0 also holds.
    step("bad0", 2'b10, 2'b10, 1'b0, 1'b0);
    step("bad1", 2'b11, 2'b10, 1'b0, 1'b0);
    step("bad2", 2'b01, 2'b00, 1'b1, 1'b0);
    step("bad3", 2'b11, 2'b00, 1'b0, 1'b0);

    // Mixed sequence from S0.
    pulses = 0;
    step("mix1", 2'b01, 2'b01, 1'b0, 1'b0);
    step("mix2", 2'b01, 2'b10, 1'b0, 1'b0);
    step("mix3", 2'b01, 2'b00, 1'b1, 1'b0);
    step("mix4", 2'b10, 2'b10, 1'b0, 1'b0);
    step("mix5", 2'b01, 2'b00, 1'b1, 1'b0);
    step("mix6", 2'b01, 2'b01, 1'b0, 1'b0);
    step("mix7", 2'b01, 2'b10, 1'b0, 1'b0);
    step("mix8", 2'b01, 2'b00, 1'b1, 1'b0);
    step("mix9", 2'b10, 2'b10, 1'b0, 1'b0);
    step("mix10", 2'b10, 2'b00, 1'b1, 1'b1);
    check("mix_pulses", pulses, 32'd4);
    step("mix_end", 2'b00, 2'b00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
